// File: rtl/hosted_sys_mem_sched_if.sv
// Bundle of the per-master AXI handshakes, the sys_mem port handshakes and the
// scheduler's select/status outputs for hosted_sys_mem_sched.
interface hosted_sys_mem_sched_if #(
  parameter int NM = 3,
  parameter int SW = (NM > 1) ? $clog2(NM) : 1
);
  logic [NM-1:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NM-1:0]   s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [NM-1:0]   s_bvalid, s_bready;
  logic [NM*8-1:0] s_awlen;
  logic            m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic            m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic            m_bvalid, m_bready;
  logic [SW-1:0]   rd_sel, wr_sel;
  logic            wlast_err;

  modport slave (
    input  s_arvalid, s_rready, s_awvalid, s_awlen, s_wvalid, s_wlast, s_bready,
    input  m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid,
    output s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
    output m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready,
    output rd_sel, wr_sel, wlast_err
  );

  modport master (
    output s_arvalid, s_rready, s_awvalid, s_awlen, s_wvalid, s_wlast, s_bready,
    output m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid,
    input  s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
    input  m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready,
    input  rd_sel, wr_sel, wlast_err
  );
endinterface

// File: rtl/hosted_sys_mem_sched.sv
// Burst-atomic round-robin scheduler for the shared sys_mem AXI port. Independent
// read and write engines; selects are exported to drive external payload muxes.
module hosted_sys_mem_sched #(
  parameter int NM = 3,
  parameter int SW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                    clk,
  input  logic                    arst,
  hosted_sys_mem_sched_if.slave   bus
);

  // First requester at or above ptr, wrapping; ptr itself when nobody asks.
  function automatic logic [SW-1:0] rr_pick(input logic [NM-1:0] req, input logic [SW-1:0] ptr);
    int idx;
    logic [SW-1:0] sel;
    sel = ptr;
    for (int k = NM-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NM) idx = idx - NM;
      if (req[idx]) sel = SW'(idx);
    end
    return sel;
  endfunction

  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] sel);
    return (int'(sel) == NM-1) ? '0 : sel + 1'b1;
  endfunction

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

  rstate_t       rstate;
  wstate_t       wstate;
  logic [SW-1:0] rd_ptr, wr_ptr, rd_sel, wr_sel;
  logic [7:0]    cnt;
  logic          wlast_err;

  logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = (rstate == R_ADDR) && bus.s_arvalid[rd_sel] && bus.m_arready;
  assign r_hs  = (rstate == R_DATA) && bus.m_rvalid && bus.s_rready[rd_sel];
  assign aw_hs = (wstate == W_ADDR) && bus.s_awvalid[wr_sel] && bus.m_awready;
  assign w_hs  = (wstate == W_DATA) && bus.s_wvalid[wr_sel] && bus.m_wready;
  assign b_hs  = (wstate == W_RESP) && bus.m_bvalid && bus.s_bready[wr_sel];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rstate <= R_IDLE;
      rd_ptr <= '0;
      rd_sel <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (|bus.s_arvalid) begin
          rd_sel <= rr_pick(bus.s_arvalid, rd_ptr);
          rstate <= R_ADDR;
        end
        R_ADDR: if (ar_hs) rstate <= R_DATA;
        R_DATA: if (r_hs && bus.m_rlast) begin
          rstate <= R_IDLE;
          rd_ptr <= nxt(rd_sel);
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // cnt holds beats remaining after the current one; zero marks the last beat.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wstate    <= W_IDLE;
      wr_ptr    <= '0;
      wr_sel    <= '0;
      cnt       <= '0;
      wlast_err <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (|bus.s_awvalid) begin
          wr_sel <= rr_pick(bus.s_awvalid, wr_ptr);
          wstate <= W_ADDR;
        end
        W_ADDR: if (aw_hs) begin
          cnt    <= bus.s_awlen[8*wr_sel +: 8];
          wstate <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          if (bus.s_wlast[wr_sel] != (cnt == 8'd0)) wlast_err <= 1'b1;
          if (cnt == 8'd0) wstate <= W_RESP;
          else             cnt    <= cnt - 8'd1;
        end
        W_RESP: if (b_hs) begin
          wstate <= W_IDLE;
          wr_ptr <= nxt(wr_sel);
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  logic [NM-1:0] s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic          m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;

  // Handshakes pass straight through to the granted master only.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (rstate)
      R_ADDR: begin
        m_arvalid         = bus.s_arvalid[rd_sel];
        s_arready[rd_sel] = bus.m_arready;
      end
      R_DATA: begin
        s_rvalid[rd_sel] = bus.m_rvalid;
        m_rready         = bus.s_rready[rd_sel];
      end
      default: ;
    endcase
  end

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    case (wstate)
      W_ADDR: begin
        m_awvalid         = bus.s_awvalid[wr_sel];
        s_awready[wr_sel] = bus.m_awready;
      end
      W_DATA: begin
        m_wvalid         = bus.s_wvalid[wr_sel];
        s_wready[wr_sel] = bus.m_wready;
        m_wlast          = (cnt == 8'd0);
      end
      W_RESP: begin
        s_bvalid[wr_sel] = bus.m_bvalid;
        m_bready         = bus.s_bready[wr_sel];
      end
      default: ;
    endcase
  end

  assign bus.s_arready = s_arready;
  assign bus.s_rvalid  = s_rvalid;
  assign bus.s_awready = s_awready;
  assign bus.s_wready  = s_wready;
  assign bus.s_bvalid  = s_bvalid;
  assign bus.m_arvalid = m_arvalid;
  assign bus.m_rready  = m_rready;
  assign bus.m_awvalid = m_awvalid;
  assign bus.m_wvalid  = m_wvalid;
  assign bus.m_wlast   = m_wlast;
  assign bus.m_bready  = m_bready;
  assign bus.rd_sel    = rd_sel;
  assign bus.wr_sel    = wr_sel;
  assign bus.wlast_err = wlast_err;

endmodule

// File: tb/tb_hosted_sys_mem_sched.sv
// Random traffic from NM masters and a random sys_mem responder, checked every
// cycle against a transaction-level round-robin model of the scheduler.
module tb_hosted_sys_mem_sched;
  localparam int NM = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  hosted_sys_mem_sched_if #(.NM(NM), .SW(SW)) bus();
  hosted_sys_mem_sched #(.NM(NM), .SW(SW)) dut (.clk(clk), .arst(arst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference state: transaction level, driven only by the observed handshakes
  int rptr, wptr, rph, wph, rg, wg;
  bit exp_err, bpend;
  int mem_rbeats;
  bit rd_req[NM], ar_done[NM], wr_req[NM], aw_done[NM];
  int rd_len[NM], awlen[NM], wsent[NM], inj[NM], ar_cnt[NM];
  int reads_done, writes_done;
  int p_req, p_ar, p_rv, p_aw, p_w, p_b, p_inj;

  function automatic int pick(input logic [NM-1:0] v, input int ptr);
    for (int k = 0; k < NM; k++) if (v[(ptr + k) % NM]) return (ptr + k) % NM;
    return -1;
  endfunction

  function automatic bit rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic model_reset();
    rptr = 0; wptr = 0; rph = 0; wph = 0; rg = 0; wg = 0;
    exp_err = 0; bpend = 0; mem_rbeats = 0;
    for (int i = 0; i < NM; i++) begin
      rd_req[i] = 0; ar_done[i] = 0; wr_req[i] = 0; aw_done[i] = 0;
      rd_len[i] = 0; awlen[i] = 0; wsent[i] = 0; inj[i] = -1; ar_cnt[i] = 0;
    end
    reads_done = 0; writes_done = 0;
  endtask

  task automatic idle_inputs();
    bus.s_arvalid = '0; bus.s_rready = '0; bus.s_awvalid = '0; bus.s_awlen = '0;
    bus.s_wvalid = '0; bus.s_wlast = '0; bus.s_bready = '0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rlast = 0; bus.m_awready = 0;
    bus.m_wready = 0; bus.m_bvalid = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid_ready"}, 64'({bus.s_arready, bus.s_rvalid, bus.s_awready, bus.s_wready,
        bus.s_bvalid, bus.m_arvalid, bus.m_rready, bus.m_awvalid, bus.m_wvalid, bus.m_bready}), 64'(0));
    chk({tag, "_rd_sel"}, 64'(bus.rd_sel), 64'(0));
    chk({tag, "_wr_sel"}, 64'(bus.wr_sel), 64'(0));
    chk({tag, "_wlast_err"}, 64'(bus.wlast_err), 64'(0));
  endtask

  // One clock: drive at negedge, check settled outputs, then advance the model.
  task automatic step();
    logic [NM-1:0] arv, rr, awv, wv, wl, br;
    logic [NM-1:0] e_arrdy, e_rv, e_awrdy, e_wrdy, e_bv;
    logic [NM*8-1:0] awl;
    logic mar, mrv, mrl, maw, mw, mb;
    int v;
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      if (!rd_req[i] && rnd(p_req)) begin
        rd_req[i] = 1; ar_done[i] = 0; rd_len[i] = $urandom_range(7);
      end
      if (!wr_req[i] && rnd(p_req)) begin
        wr_req[i] = 1; aw_done[i] = 0; wsent[i] = 0;
        awlen[i] = rnd(3) ? 255 : int'($urandom_range(7));
        inj[i] = rnd(p_inj) ? int'($urandom_range(awlen[i])) : -1;
      end
      arv[i] = rd_req[i] && !ar_done[i];
      rr[i]  = rnd(70);
      awv[i] = wr_req[i] && !aw_done[i];
      awl[8*i +: 8] = 8'(awlen[i]);
      wv[i]  = wr_req[i] && (wsent[i] <= awlen[i]) && rnd(80);
      wl[i]  = (wsent[i] == awlen[i]) ^ (inj[i] == wsent[i]);
      br[i]  = rnd(70);
    end
    mar = rnd(p_ar);
    mrv = (mem_rbeats > 0) && rnd(p_rv);
    mrl = (mem_rbeats == 1);
    maw = rnd(p_aw);
    mw  = rnd(p_w);
    mb  = bpend && rnd(p_b);
    bus.s_arvalid = arv; bus.s_rready = rr; bus.s_awvalid = awv; bus.s_awlen = awl;
    bus.s_wvalid = wv; bus.s_wlast = wl; bus.s_bready = br;
    bus.m_arready = mar; bus.m_rvalid = mrv; bus.m_rlast = mrl; bus.m_awready = maw;
    bus.m_wready = mw; bus.m_bvalid = mb;
    #1;
    e_arrdy = '0; e_rv = '0; e_awrdy = '0; e_wrdy = '0; e_bv = '0;
    if (rph == 1) e_arrdy[rg] = mar;
    if (rph == 2) e_rv[rg] = mrv;
    if (wph == 1) e_awrdy[wg] = maw;
    if (wph == 2) e_wrdy[wg] = mw;
    if (wph == 3) e_bv[wg] = mb;
    chk("m_arvalid", 64'(bus.m_arvalid), 64'(rph == 1 && arv[rg]));
    chk("s_arready", 64'(bus.s_arready), 64'(e_arrdy));
    chk("s_rvalid",  64'(bus.s_rvalid),  64'(e_rv));
    chk("m_rready",  64'(bus.m_rready),  64'(rph == 2 && rr[rg]));
    chk("rd_sel",    64'(bus.rd_sel),    64'(rg));
    chk("m_awvalid", 64'(bus.m_awvalid), 64'(wph == 1 && awv[wg]));
    chk("s_awready", 64'(bus.s_awready), 64'(e_awrdy));
    chk("m_wvalid",  64'(bus.m_wvalid),  64'(wph == 2 && wv[wg]));
    chk("s_wready",  64'(bus.s_wready),  64'(e_wrdy));
    chk("m_wlast",   64'(bus.m_wlast),   64'(wph == 2 && wsent[wg] == awlen[wg]));
    chk("s_bvalid",  64'(bus.s_bvalid),  64'(e_bv));
    chk("m_bready",  64'(bus.m_bready),  64'(wph == 3 && br[wg]));
    chk("wr_sel",    64'(bus.wr_sel),    64'(wg));
    chk("wlast_err", 64'(bus.wlast_err), 64'(exp_err));
    case (rph)
      0: begin v = pick(arv, rptr); if (v >= 0) begin rg = v; rph = 1; end end
      1: if (arv[rg] && mar) begin
        ar_done[rg] = 1; ar_cnt[rg]++; mem_rbeats = rd_len[rg] + 1; rph = 2;
      end
      default: if (mrv && rr[rg]) begin
        mem_rbeats--;
        if (mem_rbeats == 0) begin
          rph = 0; rptr = (rg + 1) % NM; rd_req[rg] = 0; reads_done++;
        end
      end
    endcase
    case (wph)
      0: begin v = pick(awv, wptr); if (v >= 0) begin wg = v; wph = 1; end end
      1: if (awv[wg] && maw) begin aw_done[wg] = 1; wph = 2; end
      2: if (wv[wg] && mw) begin
        if (wl[wg] != (wsent[wg] == awlen[wg])) exp_err = 1;
        if (wsent[wg] == awlen[wg]) begin wph = 3; bpend = 1; end
        wsent[wg]++;
      end
      default: if (mb && br[wg]) begin
        wph = 0; bpend = 0; wptr = (wg + 1) % NM; wr_req[wg] = 0; writes_done++;
      end
    endcase
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 arst = 1;
    #1 chk_all_zero(tag);
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    arst = 0;
  endtask

  task automatic run_seg(input string tag, input int cycles);
    int mx, mn;
    for (int c = 0; c < cycles; c++) step();
    chk({tag, "_reads_done"},  64'(reads_done > 0),  64'(1));
    chk({tag, "_writes_done"}, 64'(writes_done > 0), 64'(1));
    mx = ar_cnt[0]; mn = ar_cnt[0];
    for (int i = 1; i < NM; i++) begin
      if (ar_cnt[i] > mx) mx = ar_cnt[i];
      if (ar_cnt[i] < mn) mn = ar_cnt[i];
    end
    if (p_req == 100) chk({tag, "_ar_fairness"}, 64'(mx - mn <= 1), 64'(1));
  endtask

  initial begin
    arst = 1;
    idle_inputs();
    model_reset();
    #3 chk_all_zero("por");
    repeat (2) @(negedge clk);
    arst = 0;

    // clean traffic, no WLAST corruption
    p_req = 30; p_ar = 60; p_rv = 60; p_aw = 60; p_w = 60; p_b = 60; p_inj = 0;
    run_seg("seg0", 3000);
    chk("seg0_err_clean", 64'(bus.wlast_err), 64'(0));
    async_reset("rst0");

    // sys_mem address back-pressure and occasional bad WLAST
    p_req = 50; p_ar = 10; p_rv = 80; p_aw = 10; p_w = 50; p_b = 40; p_inj = 10;
    run_seg("seg1", 3000);
    async_reset("rst1");

    // every master always requesting, sys_mem always ready
    p_req = 100; p_ar = 100; p_rv = 100; p_aw = 100; p_w = 100; p_b = 100; p_inj = 0;
    run_seg("seg2", 2000);
    async_reset("rst2");

    for (int c = 0; c < 4; c++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
